// File: rtl/ce_div.sv
// Iterative radix-2 restoring divider for the HI/LO path (DIV/DIVU).
// Quotient goes to LO, remainder to HI; a registered halt holds back HI/LO readers while busy.
module ce_div #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned HALT_DRV = 4
) (
   input  logic                CLK,
   input  logic                RESET_D1_R_N,
   input  logic                CEI_CEHOLD,
   input  logic                CEI_XCPN_M,
   input  logic                DIV_START_S,
   input  logic                HL_READ_S,
   input  logic                DIV_START_E_R,
   input  logic                DIV_SIGNED_E_R,
   input  logic [WIDTH-1:0]    CEI_AOP_E_R,
   input  logic [WIDTH-1:0]    CEI_BOP_E_R,
   output logic                DIV_BUSY,
   output logic [HALT_DRV-1:0] DIV_HALT_E_R_C,
   output logic                DIV_HI_WR,
   output logic                DIV_LO_WR,
   output logic [WIDTH-1:0]    DIV_HI_RES,
   output logic [WIDTH-1:0]    DIV_LO_RES
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [2:0] {StIdle, StArm, StRun, StFix, StDone} state_e;

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic             sign_a_q, sign_a_d;
   logic             sign_x_q, sign_x_d;
   logic             halt_q, halt_d;

   logic             accept, load;
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_abs, b_abs;
   logic [WIDTH:0]   rem_sh, trial;

   assign accept = DIV_START_E_R & ~CEI_CEHOLD & ~halt_q & ~CEI_XCPN_M;
   assign load   = accept & ((state_q == StIdle) | (state_q == StDone));

   assign a_neg = DIV_SIGNED_E_R & CEI_AOP_E_R[WIDTH-1];
   assign b_neg = DIV_SIGNED_E_R & CEI_BOP_E_R[WIDTH-1];
   assign a_abs = a_neg ? -CEI_AOP_E_R : CEI_AOP_E_R;
   assign b_abs = b_neg ? -CEI_BOP_E_R : CEI_BOP_E_R;

   // One restoring step: shift {rem,quo} left and trial-subtract the divisor.
   assign rem_sh = {rem_q, quo_q[WIDTH-1]};
   assign trial  = rem_sh - {1'b0, dvs_q};

   always_ff @(posedge CLK or negedge RESET_D1_R_N) begin
      if (!RESET_D1_R_N) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (accept) state_d = StArm;
         StArm: begin
            if (CEI_XCPN_M) begin
               state_d = StIdle;
            end else if (dvs_q == '0) begin
               state_d = StFix;
            end else begin
               state_d = StRun;
            end
         end
         StRun:  if (cnt_q == '0) state_d = StFix;
         StFix:  state_d = StDone;
         StDone: state_d = accept ? StArm : StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      DIV_BUSY       = (state_q == StArm) | (state_q == StRun) | (state_q == StFix);
      DIV_HI_WR      = (state_q == StDone);
      DIV_LO_WR      = (state_q == StDone);
      DIV_HI_RES     = rem_q;
      DIV_LO_RES     = quo_q;
      DIV_HALT_E_R_C = {HALT_DRV{halt_q}};
   end

   // Halt also covers the DONE cycle so a stalled MFHI/MFLO reads the freshly written HI/LO.
   assign halt_d = (HL_READ_S | DIV_START_S) & (state_d != StIdle) & ~CEI_XCPN_M;

   always_comb begin
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvs_d    = dvs_q;
      sign_a_d = sign_a_q;
      sign_x_d = sign_x_q;
      if (load) begin
         rem_d    = '0;
         quo_d    = a_abs;
         dvs_d    = b_abs;
         sign_a_d = a_neg;
         sign_x_d = a_neg ^ b_neg;
      end else begin
         unique case (state_q)
            StArm: cnt_d = CntW'(WIDTH - 1);
            StRun: begin
               rem_d = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
               if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            end
            StFix: begin
               // Divide by zero: quo_q still holds |A|, so re-signing it restores the dividend.
               if (dvs_q == '0) begin
                  quo_d = '1;
                  rem_d = sign_a_q ? -quo_q : quo_q;
               end else begin
                  quo_d = sign_x_q ? -quo_q : quo_q;
                  rem_d = sign_a_q ? -rem_q : rem_q;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESET_D1_R_N) begin
      if (!RESET_D1_R_N) begin
         cnt_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         sign_a_q <= 1'b0;
         sign_x_q <= 1'b0;
         halt_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvs_q    <= dvs_d;
         sign_a_q <= sign_a_d;
         sign_x_q <= sign_x_d;
         halt_q   <= halt_d;
      end
   end

endmodule
